regbank_wb_scheduler: RTL

Write-back scheduler for the 16 x 32-bit register bank. It arbitrates the bank's single write port between the ALU result path and the memory load path using round-robin priority. It keeps a 16-entry pending-write scoreboard so the issue stage can stall on RAW/WAW hazards. It sits between execute/memory and the register bank, driving the bank's dest/Din inputs.

---
 rtl/regbank_pkg.sv | 15 +
 rtl/rr_arbiter2.sv | 32 +++
 rtl/regbank_wb_scheduler.sv | 90 +++++++++
 3 files changed

// File: rtl/regbank_pkg.sv
// Shared types and constants for the register-bank write-back path.
// Imported by the scheduler and its round-robin arbiter.
package regbank_pkg;

    localparam int REG_ADDR_W = 4;
    localparam int NUM_REGS   = 16;

    localparam logic [3:0] OPC_NOP = 4'b1111;

    typedef enum logic {
        SEL_ALU,
        SEL_MEM
    } rr_sel_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin grant for the bank write port.
// Pointer moves to the loser only on contested cycles.
module rr_arbiter2
    import regbank_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic alu_valid,
    input  logic mem_valid,
    output logic alu_grant,
    output logic mem_grant
);

    rr_sel_t rr_ptr;
    logic    contested;

    assign contested = alu_valid && mem_valid;

    assign alu_grant = !reset && alu_valid &&
                       (!mem_valid || rr_ptr == SEL_ALU);
    assign mem_grant = !reset && mem_valid &&
                       (!alu_valid || rr_ptr == SEL_MEM);

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= SEL_ALU;
        end else if (contested) begin
            rr_ptr <= alu_grant ? SEL_MEM : SEL_ALU;
        end
    end

endmodule

// File: rtl/regbank_wb_scheduler.sv
// Write-back scheduler: arbitrates the bank write port between ALU
// and load results and tracks outstanding writes for hazard stalls.
module regbank_wb_scheduler
    import regbank_pkg::*;
#(
    parameter int         DATA_W  = 32,
    parameter logic [3:0] OPC_NOP = regbank_pkg::OPC_NOP
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  iss_valid,
    input  logic [REG_ADDR_W-1:0] iss_dest,
    input  logic [REG_ADDR_W-1:0] iss_src1,
    input  logic [REG_ADDR_W-1:0] iss_src2,
    output logic                  iss_stall,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [REG_ADDR_W-1:0] alu_dest,
    input  logic [3:0]            alu_opcode,
    input  logic [DATA_W-1:0]     alu_data,
    input  logic                  mem_valid,
    output logic                  mem_ready,
    input  logic [REG_ADDR_W-1:0] mem_dest,
    input  logic [3:0]            mem_opcode,
    input  logic [DATA_W-1:0]     mem_data,
    output logic                  wr_en,
    output logic [REG_ADDR_W-1:0] wr_dest,
    output logic [DATA_W-1:0]     wr_data,
    output logic [NUM_REGS-1:0]   pend
);

    logic                  xfer;
    logic                  iss_fire;
    logic                  do_write;
    logic [REG_ADDR_W-1:0] x_dest;
    logic [3:0]            x_opc;
    logic [DATA_W-1:0]     x_data;
    logic [NUM_REGS-1:0]   pend_q;
    logic [NUM_REGS-1:0]   pend_nxt;

    rr_arbiter2 u_arb (
        .clk       (clk),
        .reset     (reset),
        .alu_valid (alu_valid),
        .mem_valid (mem_valid),
        .alu_grant (alu_ready),
        .mem_grant (mem_ready)
    );

    assign xfer     = alu_ready || mem_ready;
    assign x_dest   = mem_ready ? mem_dest   : alu_dest;
    assign x_opc    = mem_ready ? mem_opcode : alu_opcode;
    assign x_data   = mem_ready ? mem_data   : alu_data;
    assign do_write = xfer && (x_opc != OPC_NOP);

    assign iss_stall = iss_valid &&
                       (pend_q[iss_src1] ||
                        pend_q[iss_src2] ||
                        pend_q[iss_dest]);
    assign iss_fire  = iss_valid && !iss_stall;
    assign pend      = pend_q;

    // Set applied after clear: the newly issued producer is younger.
    always_comb begin
        pend_nxt = pend_q;
        if (xfer) begin
            pend_nxt[x_dest] = 1'b0;
        end
        if (iss_fire) begin
            pend_nxt[iss_dest] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q  <= '0;
            wr_en   <= 1'b0;
            wr_dest <= '0;
            wr_data <= '0;
        end else begin
            pend_q <= pend_nxt;
            wr_en  <= do_write;
            if (do_write) begin
                wr_dest <= x_dest;
                wr_data <= x_data;
            end
        end
    end

endmodule
